// File: rtl/sent_tx_crc_engine.sv
// Bit-serial CRC engine shared by all SENT frame types: CRC4 over 1..MAX_NIBBLES
// data nibbles or the 6-bit enhanced-serial CRC over a 24-bit message.
module sent_tx_crc_engine #(
  parameter int         MAX_NIBBLES = 6,
  parameter logic [4:0] POLY4       = 5'b11101,
  parameter logic [3:0] SEED4       = 4'b0101,
  parameter logic [6:0] POLY6       = 7'b1011001,
  parameter logic [5:0] SEED6       = 6'b010101
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      start,
  input  logic                                                      mode,
  input  logic [3:0]                                                num_nibbles,
  input  logic [((4*MAX_NIBBLES > 24) ? 4*MAX_NIBBLES : 24)-1:0]    data_in,
  output logic                                                      busy,
  output logic                                                      done,
  output logic                                                      err,
  output logic [5:0]                                                crc_out
);

  localparam int DW     = (4*MAX_NIBBLES > 24) ? 4*MAX_NIBBLES : 24;
  localparam int CW_MIN = $clog2(4*MAX_NIBBLES+5);
  localparam int CW     = (CW_MIN > 5) ? CW_MIN : 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [5:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    crc_q, crc_d;
  logic          err_q, err_d;

  logic          bit_in;
  logic [5:0]    r_step;
  logic          legal;

  // One long-division step; the message is left-aligned in sh_q so zeros
  // shifting in from the bottom supply the W trailing zero bits.
  always_comb begin
    bit_in = sh_q[DW-1];
    if (mode_q) begin
      r_step = {r_q[4:0], bit_in} ^ (r_q[5] ? POLY6[5:0] : 6'd0);
    end else begin
      r_step = {2'b00, r_q[2:0], bit_in} ^ (r_q[3] ? {2'b00, POLY4[3:0]} : 6'd0);
    end
  end

  assign legal = mode || ((num_nibbles != 4'd0) && ({28'd0, num_nibbles} <= 32'(MAX_NIBBLES)));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sh_d    = sh_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          crc_d = 6'd0;
          if (legal) begin
            state_d = SHIFT;
            mode_d  = mode;
            err_d   = 1'b0;
            if (mode) begin
              r_d   = SEED6;
              cnt_d = CW'(30);
              sh_d  = DW'(data_in[23:0]) << (DW - 24);
            end else begin
              r_d   = {2'b00, SEED4};
              cnt_d = CW'({num_nibbles, 2'b00}) + CW'(4);
              sh_d  = data_in << (DW - 4*int'(num_nibbles));
            end
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_q << 1;
        r_d   = r_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          crc_d   = r_step;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sh_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign crc_out = crc_q;

endmodule

// File: tb/tb_sent_tx_crc_engine.sv
// Directed and model-checked bench for sent_tx_crc_engine: table vectors,
// random CRC4/CRC6 messages, and handshake/reset corner sequences.
module tb_sent_tx_crc_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [3:0]  num_nibbles;
  logic [23:0] data_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  crc_out;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic        mode;
    logic [3:0]  nn;
    logic [23:0] data;
    logic [5:0]  crc;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sent_tx_crc_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .num_nibbles (num_nibbles),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .crc_out     (crc_out)
  );

  // Textbook long division of {seed, message, W zeros} by the full generator.
  function automatic logic [5:0] crcModel(input logic m, input logic [3:0] n, input logic [23:0] d);
    logic [63:0] dv;
    int          total;
    if (!m) begin
      if (n == 4'd0 || n > 4'd6) return 6'd0;
      dv = (64'(4'b0101) << (4*int'(n) + 4))
         | ((64'(d) & ((64'd1 << (4*int'(n))) - 64'd1)) << 4);
      total = 4*int'(n) + 8;
      for (int i = total-1; i >= 4; i--)
        if (dv[i]) dv[i-:5] = dv[i-:5] ^ 5'b11101;
      return {2'b00, dv[3:0]};
    end else begin
      dv = (64'(6'b010101) << 30) | (64'(d) << 6);
      for (int i = 35; i >= 6; i--)
        if (dv[i]) dv[i-:7] = dv[i-:7] ^ 7'b1011001;
      return dv[5:0];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [3:0] n, input logic [23:0] d,
                               input logic [5:0] exp_crc, input logic exp_err,
                               input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    mode = m; num_nibbles = n; data_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput($sformatf("%s busy@accept", tag), 32'(busy), 32'd1);
    checkOutput($sformatf("%s crc cleared", tag), 32'(crc_out), 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("%s done", tag), 32'(done), 32'd1);
    checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    checkOutput($sformatf("%s crc", tag), 32'(crc_out), 32'(exp_crc));
    checkOutput($sformatf("%s err", tag), 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    checkOutput($sformatf("%s busy after", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s done pulse", tag), 32'(done), 32'd0);
    checkOutput($sformatf("%s crc held", tag), 32'(crc_out), 32'(exp_crc));
  endtask

  initial begin
    int          lat;
    int          cyc;
    int          accepts;
    int          last_acc;
    logic        prev_busy;
    logic [3:0]  n;
    logic [23:0] d;

    vecs[0] = '{1'b0, 4'd3, 24'h0002C7, 6'h06, 1'b0, 16};
    vecs[1] = '{1'b0, 4'd1, 24'h000000, 6'h0A, 1'b0, 8};
    vecs[2] = '{1'b1, 4'd0, 24'h000000, 6'h26, 1'b0, 30};
    vecs[3] = '{1'b0, 4'd0, 24'h000123, 6'h00, 1'b1, 0};
    vecs[4] = '{1'b0, 4'd7, 24'hABCDEF, 6'h00, 1'b1, 0};
    vecs[5] = '{1'b0, 4'd3, 24'h0002C7, 6'h06, 1'b0, 16};
    vecs[6] = '{1'b1, 4'd9, 24'h000000, 6'h26, 1'b0, 30};

    reset = 1'b1; start = 1'b0; mode = 1'b0; num_nibbles = 4'd0; data_in = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset crc", 32'(crc_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].mode, vecs[i].nn, vecs[i].data, vecs[i].crc, vecs[i].err,
                    vecs[i].lat, $sformatf("vec%0d", i));

    for (int k = 0; k < 1000; k++) begin
      n = 4'($urandom_range(1, 6));
      d = 24'($urandom);
      applyStimulus(1'b0, n, d, crcModel(1'b0, n, d), 1'b0, 4*int'(n) + 4, $sformatf("rnd4_%0d", k));
    end
    for (int k = 0; k < 200; k++) begin
      d = 24'($urandom);
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), d, crcModel(1'b1, 4'd0, d), 1'b0, 30,
                    $sformatf("rnd6_%0d", k));
    end

    // start held high: one accept every L+2 = 18 cycles
    @(negedge clk);
    mode = 1'b0; num_nibbles = 4'd3; data_in = 24'h0002C7; start = 1'b1;
    prev_busy = 1'b0; accepts = 0; last_acc = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        if (accepts > 0) checkOutput("held start spacing", 32'(cyc - last_acc), 32'd18);
        accepts++;
        last_acc = cyc;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checkOutput("held start accepts", 32'(accepts), 32'd4);
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("held start drain", 32'(busy), 32'd0);
    checkOutput("held start crc", 32'(crc_out), 32'h06);

    // start pulsed mid-SHIFT and in DONE, inputs scrambled during SHIFT
    @(negedge clk);
    mode = 1'b0; num_nibbles = 4'd3; data_in = 24'h0002C7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      data_in = 24'($urandom);
      mode = ~mode;
      num_nibbles = 4'($urandom_range(0, 15));
      start = (lat == 5);
    end
    start = 1'b0;
    checkOutput("toggle done", 32'(done), 32'd1);
    checkOutput("toggle latency", 32'(lat), 32'd16);
    checkOutput("toggle crc", 32'(crc_out), 32'h06);
    checkOutput("toggle err", 32'(err), 32'd0);
    mode = 1'b0; num_nibbles = 4'd1; data_in = 24'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start in done ignored", 32'(busy), 32'd0);
    checkOutput("start in done crc", 32'(crc_out), 32'h06);

    // reset in cycle 5 of a CRC6 run aborts it
    @(negedge clk);
    mode = 1'b1; num_nibbles = 4'd0; data_in = 24'hABCDEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort crc", 32'(crc_out), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 4'd0, 24'h5A5A5A, crcModel(1'b1, 4'd0, 24'h5A5A5A), 1'b0, 30, "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
